// File: rtl/obg_frame_seq.sv
// Frame sequencer for the original-bits generator: signal field, then payload, then done.
// Optional stall timeout is compiled in with OBG_SEQ_TIMEOUT_EN.
module obg_frame_seq #(
    parameter int SIG_BITS  = 24,
    parameter int TO_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    input  logic [15:0] req_len,
    input  logic [3:0]  req_type,
    output logic        req_rdy,
    output logic [15:0] ssg_di_len,
    output logic [3:0]  ssg_di_type,
    output logic        ssg_di_vld,
    input  logic        ssg_do_vld,
    output logic        new_frame,
    input  logic        pld_do_vld,
    output logic [1:0]  sel,
    output logic        frame_done,
    output logic        err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SIG_START = 3'd1;
    localparam logic [2:0] SIG_RUN   = 3'd2;
    localparam logic [2:0] PLD_START = 3'd3;
    localparam logic [2:0] PLD_RUN   = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    logic [2:0]  state, nxt;
    logic [19:0] cnt, target;
    logic        sig_last, pld_last, timeout;

    assign sig_last = ssg_do_vld && (cnt == 20'(SIG_BITS - 1));
    assign pld_last = pld_do_vld && (cnt == target - 20'd1);

`ifdef OBG_SEQ_TIMEOUT_EN
    localparam int SW = $clog2(TO_CYCLES + 1);
    logic [SW-1:0] stall;
    logic          idle_cyc;

    // Consecutive cycles in a run state without the valid we are waiting for.
    assign idle_cyc = ((state == SIG_RUN) && !ssg_do_vld) || ((state == PLD_RUN) && !pld_do_vld);
    assign timeout  = idle_cyc && (stall == SW'(TO_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall <= '0;
        else if (idle_cyc && !timeout)
            stall <= stall + 1'b1;
        else
            stall <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (req_vld) nxt = SIG_START;
            SIG_START: nxt = SIG_RUN;
            SIG_RUN:   if (sig_last) nxt = PLD_START; else if (timeout) nxt = IDLE;
            PLD_START: nxt = PLD_RUN;
            PLD_RUN:   if (pld_last) nxt = DONE; else if (timeout) nxt = IDLE;
            DONE:      nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every one of them leaves a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            target      <= '0;
            ssg_di_len  <= '0;
            ssg_di_type <= '0;
            req_rdy     <= 1'b1;
            ssg_di_vld  <= 1'b0;
            new_frame   <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            sel         <= 2'd0;
        end else begin
            state      <= nxt;
            req_rdy    <= (nxt == IDLE);
            ssg_di_vld <= (nxt == SIG_START);
            new_frame  <= (nxt == PLD_START);
            frame_done <= (nxt == DONE);
            err        <= timeout;
            if (nxt == SIG_START || nxt == SIG_RUN)
                sel <= 2'd1;
            else if (nxt == PLD_START || nxt == PLD_RUN)
                sel <= 2'd2;
            else
                sel <= 2'd0;

            if (state == IDLE && req_vld) begin
                ssg_di_len  <= req_len;
                ssg_di_type <= req_type;
            end

            case (state)
                SIG_RUN: if (ssg_do_vld) cnt <= cnt + 20'd1;
                PLD_RUN: if (pld_do_vld) cnt <= cnt + 20'd1;
                default: cnt <= '0;
            endcase

            // 16 service + 8*len data + 6 tail bits; fits 20 bits for any len.
            if (state == PLD_START)
                target <= {1'b0, ssg_di_len, 3'b000} + 20'd22;
        end
    end

endmodule

// File: tb/tb_obg_frame_seq.sv
// Scoreboard bench for obg_frame_seq: stimulus pushes expected pulses, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_obg_frame_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld;
    logic [15:0] req_len;
    logic [3:0]  req_type;
    logic        req_rdy;
    logic [15:0] ssg_di_len;
    logic [3:0]  ssg_di_type;
    logic        ssg_di_vld;
    logic        ssg_do_vld;
    logic        new_frame;
    logic        pld_do_vld;
    logic [1:0]  sel;
    logic        frame_done;
    logic        err;

    obg_frame_seq #(.SIG_BITS(24), .TO_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_len(req_len), .req_type(req_type), .req_rdy(req_rdy),
        .ssg_di_len(ssg_di_len), .ssg_di_type(ssg_di_type), .ssg_di_vld(ssg_di_vld),
        .ssg_do_vld(ssg_do_vld), .new_frame(new_frame), .pld_do_vld(pld_do_vld),
        .sel(sel), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    // kind: 0 = start {type,len}, 1 = new_frame (signal valids), 2 = done (payload valids), 3 = err
    typedef struct {
        int kind;
        int data;
    } ev_t;

    ev_t exq[$];
    int  checks = 0;
    int  errors = 0;
    int  n_ev[4] = '{0, 0, 0, 0};
    int  sig_cnt = 0;
    int  pld_cnt = 0;
    int  cyc = 0;
    int  done_cyc = 0;
    int  gap = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exq.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int data, input string nm);
        ev_t e;
        if (exq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected pulse data %0d", nm, data);
        end else begin
            e = exq.pop_front();
            check({nm, "_kind"}, kind, e.kind);
            check({nm, "_data"}, data, e.data);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (ssg_di_vld) begin
                pop_cmp(0, int'(ssg_di_type) * 65536 + int'(ssg_di_len), "start");
                check("start_sel", int'(sel), 1);
                gap = cyc - done_cyc;
                sig_cnt = 0;
                n_ev[0]++;
            end
            if (new_frame) begin
                pop_cmp(1, sig_cnt, "new_frame");
                check("new_frame_sel", int'(sel), 2);
                pld_cnt = 0;
                n_ev[1]++;
            end
            if (frame_done) begin
                pop_cmp(2, pld_cnt, "frame_done");
                check("done_sel", int'(sel), 0);
                done_cyc = cyc;
                n_ev[2]++;
            end
            if (err) begin
                pop_cmp(3, pld_cnt, "err");
                check("err_rdy", int'(req_rdy), 1);
                n_ev[3]++;
            end
            // Valids presented now are sampled at the next edge in the run states.
            if (sel == 2'd1 && !ssg_di_vld && ssg_do_vld) sig_cnt++;
            if (sel == 2'd2 && !new_frame && pld_do_vld) pld_cnt++;
        end
    end

    task automatic wait_ev(input int kind, input int target, input string nm);
        for (int i = 0; i < 3000 && n_ev[kind] < target; i++) begin
            @(posedge clk);
            #1;
        end
        if (n_ev[kind] < target) check({nm, "_timeout"}, n_ev[kind], target);
    endtask

    task automatic wait_pld(input int target, input string nm);
        for (int i = 0; i < 3000 && pld_cnt < target; i++) begin
            @(posedge clk);
            #1;
        end
        if (pld_cnt < target) check({nm, "_timeout"}, pld_cnt, target);
    endtask

    task automatic issue(input logic [15:0] len, input logic [3:0] ty);
        for (int i = 0; i < 3000 && !req_rdy; i++) begin
            @(posedge clk);
            #1;
        end
        if (!req_rdy) check("req_rdy_timeout", int'(req_rdy), 1);
        req_len  = len;
        req_type = ty;
        req_vld  = 1'b1;
        @(posedge clk);
        #1;
        req_vld = 1'b0;
    endtask

    task automatic push_frame(input int len, input int ty);
        push(0, ty * 65536 + len);
        push(1, 24);
        push(2, 8 * len + 22);
    endtask

    task automatic reset_checks(input string nm);
        check({nm, "_rdy"}, int'(req_rdy), 1);
        check({nm, "_len"}, int'(ssg_di_len), 0);
        check({nm, "_type"}, int'(ssg_di_type), 0);
        check({nm, "_sel"}, int'(sel), 0);
        check({nm, "_pulses"}, int'({ssg_di_vld, new_frame, frame_done, err}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int s0;
        rst = 1'b1; req_vld = 1'b0; req_len = '0; req_type = '0;
        ssg_do_vld = 1'b1; pld_do_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Nominal frame, valids continuous (and ignored outside the run states).
        push_frame(100, 11);
        issue(16'd100, 4'hB);
        wait_ev(2, 1, "nominal");

        // Zero length with a stall after 21 payload valids.
        push_frame(0, 3);
        issue(16'd0, 4'h3);
        wait_ev(1, 2, "zero_nf");
        wait_pld(21, "zero_stall");
        pld_do_vld = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("zero_stall_sel", int'(sel), 2);
        check("zero_stall_done", n_ev[2], 1);
        pld_do_vld = 1'b1;
        wait_ev(2, 2, "zero");

        // Request while busy is dropped.
        push_frame(10, 2);
        issue(16'd10, 4'h2);
        wait_pld(20, "busy_pld");
        req_len = 16'd5; req_type = 4'h7; req_vld = 1'b1;
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        check("busy_len", int'(ssg_di_len), 10);
        wait_ev(2, 3, "busy");
        repeat (6) @(posedge clk);
        #1;
        check("busy_starts", n_ev[0], 3);
        check("busy_len_hold", int'(ssg_di_len), 10);

        // Reset in the middle of the payload.
        push(0, 1 * 65536 + 40);
        push(1, 24);
        issue(16'd40, 4'h1);
        wait_pld(300, "rst_pld");
        #2 rst = 1'b1;
        #1;
        reset_checks("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_frame(1, 5);
        issue(16'd1, 4'h5);
        wait_ev(2, 4, "after_rst");

        // Back-to-back with req_vld held high.
        push_frame(2, 6);
        push_frame(3, 6);
        d0 = n_ev[2];
        s0 = n_ev[0];
        req_len = 16'd2; req_type = 4'h6; req_vld = 1'b1;
        wait_ev(0, s0 + 1, "b2b_first");
        req_len = 16'd3;
        wait_ev(0, s0 + 2, "b2b_second");
        req_vld = 1'b0;
        check("b2b_gap", gap, 2);
        wait_ev(2, d0 + 2, "b2b");

        // Payload stall until timeout (or indefinite wait).
        push(0, 4 * 65536 + 10);
        push(1, 24);
`ifdef OBG_SEQ_TIMEOUT_EN
        push(3, 5);
`endif
        d0 = n_ev[2];
        issue(16'd10, 4'h4);
        wait_pld(5, "to_pld");
        pld_do_vld = 1'b0;
`ifdef OBG_SEQ_TIMEOUT_EN
        wait_ev(3, 1, "to_err");
        @(posedge clk);
        #1;
        check("to_idle_rdy", int'(req_rdy), 1);
`else
        repeat (40) @(posedge clk);
        #1;
        check("to_hold_sel", int'(sel), 2);
        check("to_hold_err", int'(err), 0);
        check("to_hold_rdy", int'(req_rdy), 0);
`endif
        check("to_no_done", n_ev[2], d0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pld_do_vld = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        check("queue_empty", exq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
